// File: rtl/pipe_reg_elastic.sv
`default_nettype none
// ============================================================================
// Module   : pipe_reg_elastic
// Purpose  : DEPTH-stage elastic register pipeline with collapsing bubbles,
//            valid/ready on both ends, flush and occupancy count.
//            Optional per-stage parity with sticky error: PIPE_REG_PARITY_EN.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_reg_elastic #(
    parameter int              WIDTH     = 8,
    parameter int              DEPTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic [$clog2(DEPTH+1)-1:0] count
`ifdef PIPE_REG_PARITY_EN
    ,
    output logic                       par_err
`endif
);

    localparam int CW = $clog2(DEPTH+1);

    logic [DEPTH-1:0]            r_v;
    logic [DEPTH-1:0][WIDTH-1:0] r_d;
    logic [CW-1:0]               r_count;
    logic [DEPTH-1:0]            w_rdy;
    logic                        w_push;
    logic                        w_pop;

    // A stage can advance if the output is being drained or any stage at or
    // beyond it is empty; written as a flat reduction to avoid a ripple loop.
    for (genvar i = 0; i < DEPTH; i++) begin : g_rdy
        assign w_rdy[i] = out_ready | ~(&r_v[DEPTH-1:i]);
    end

    assign in_ready  = w_rdy[0] & ~flush;
    assign w_push    = in_valid & in_ready;
    assign w_pop     = r_v[DEPTH-1] & out_ready;
    assign out_valid = r_v[DEPTH-1];
    assign out_data  = r_d[DEPTH-1];
    assign count     = r_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_v     <= '0;
            r_d     <= {DEPTH{RESET_VAL}};
            r_count <= '0;
        end else begin
            if (flush) begin
                r_v     <= '0;
                r_count <= '0;
            end else begin
                if (w_rdy[0]) begin
                    r_v[0] <= w_push;
                end
                for (int i = 1; i < DEPTH; i++) begin
                    if (w_rdy[i]) begin
                        r_v[i] <= r_v[i-1];
                    end
                end
                r_count <= r_count + CW'(w_push) - CW'(w_pop);
            end
            // Data only moves with a valid word, so bubbles never overwrite it.
            if (w_rdy[0] && w_push) begin
                r_d[0] <= in_data;
            end
            for (int i = 1; i < DEPTH; i++) begin
                if (w_rdy[i] && r_v[i-1]) begin
                    r_d[i] <= r_d[i-1];
                end
            end
        end
    end

`ifdef PIPE_REG_PARITY_EN
    logic [DEPTH-1:0] r_p;
    logic             r_par_err;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_p <= '0;
        end else begin
            if (w_rdy[0] && w_push) begin
                r_p[0] <= ^in_data;
            end
            for (int i = 1; i < DEPTH; i++) begin
                if (w_rdy[i] && r_v[i-1]) begin
                    r_p[i] <= r_p[i-1];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_par_err <= 1'b0;
        end else if (flush) begin
            r_par_err <= 1'b0;
        end else if (r_v[DEPTH-1] && ((^r_d[DEPTH-1]) != r_p[DEPTH-1])) begin
            r_par_err <= 1'b1;
        end
    end

    assign par_err = r_par_err;
`endif

endmodule
`default_nettype wire
